// File: rtl/palm_locator.sv
// palm_locator: scans a raster-ordered binary image and publishes the bounding
// box of the first vertical block of rows that each hold a wide run of object
// pixels. A zero box means no palm was found.
//
// Handshake: a pixel is consumed on any clock edge where pixel_valid is high
// while the block is in IDLE with frame_start high, or in SCAN. There is no
// backpressure. palm_done is a one-cycle strobe that marks the box outputs as
// freshly updated.
module palm_locator #(
    parameter int IMAGE_WIDTH   = 120,
    parameter int IMAGE_HEIGHT  = 160,
    parameter int MIN_PALM_RUN  = 20,
    parameter int MIN_PALM_ROWS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_start,
    input  logic       pixel_valid,
    input  logic       object_image,
    output logic [7:0] palm_width,
    output logic [7:0] palm_height,
    output logic [7:0] start_of_palm_r,
    output logic [7:0] start_of_palm_c,
    output logic [7:0] end_of_palm_r,
    output logic [7:0] end_of_palm_c,
    output logic       palm_done,
    output logic       busy
);

    localparam logic [7:0] LAST_COL = 8'(IMAGE_WIDTH - 1);
    localparam logic [7:0] LAST_ROW = 8'(IMAGE_HEIGHT - 1);
    localparam logic [7:0] MIN_RUN  = 8'(MIN_PALM_RUN);
    localparam logic [7:0] MIN_ROWS = 8'(MIN_PALM_ROWS);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_CLOSE, S_PUBLISH} state_t;
    state_t state_q, state_d;

    // Pixel position and per-row run trackers.
    logic [7:0] col_q, col_d, row_q, row_d;
    logic [7:0] cur_len_q, cur_len_d, cur_start_q, cur_start_d;
    logic [7:0] max_len_q, max_len_d, max_start_q, max_start_d, max_end_q, max_end_d;
    // Currently open block of qualifying rows.
    logic       blk_open_q, blk_open_d;
    logic [7:0] blk_start_r_q, blk_start_r_d, blk_end_r_q, blk_end_r_d;
    logic [7:0] blk_rows_q, blk_rows_d, blk_min_c_q, blk_min_c_d, blk_max_c_q, blk_max_c_d;
    // First accepted block of the frame.
    logic       cap_valid_q, cap_valid_d;
    logic [7:0] cap_start_r_q, cap_start_r_d, cap_end_r_q, cap_end_r_d;
    logic [7:0] cap_start_c_q, cap_start_c_d, cap_end_c_q, cap_end_c_d;
    // Published outputs.
    logic [7:0] palm_width_q, palm_width_d, palm_height_q, palm_height_d;
    logic [7:0] start_r_q, start_r_d, start_c_q, start_c_d, end_r_q, end_r_d, end_c_q, end_c_d;
    logic       palm_done_q, palm_done_d;

    logic       accept, restart, row_end, frame_end, qualifies, close_blk;
    logic [7:0] eff_col, eff_row, run_len, run_start;

    // Pixel acceptance and the position the accepted pixel occupies.
    always_comb begin
        accept    = pixel_valid && ((state_q == S_IDLE && frame_start) || state_q == S_SCAN);
        restart   = accept && frame_start;
        eff_col   = restart ? 8'd0 : col_q;
        eff_row   = restart ? 8'd0 : row_q;
        row_end   = (eff_col == LAST_COL);
        frame_end = accept && row_end && (eff_row == LAST_ROW);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (accept) state_d = frame_end ? S_CLOSE : S_SCAN;
            S_SCAN:    if (frame_end) state_d = S_CLOSE;
            S_CLOSE:   state_d = S_PUBLISH;
            S_PUBLISH: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output logic: busy flag and the values loaded when publishing.
    always_comb begin
        busy          = (state_q == S_SCAN) || (state_q == S_CLOSE);
        palm_done_d   = (state_q == S_PUBLISH);
        palm_width_d  = palm_width_q;
        palm_height_d = palm_height_q;
        start_r_d     = start_r_q;
        start_c_d     = start_c_q;
        end_r_d       = end_r_q;
        end_c_d       = end_c_q;
        if (state_q == S_PUBLISH) begin
            if (cap_valid_q) begin
                palm_width_d  = cap_end_c_q - cap_start_c_q + 8'd1;
                palm_height_d = cap_end_r_q - cap_start_r_q + 8'd1;
                start_r_d     = cap_start_r_q;
                start_c_d     = cap_start_c_q;
                end_r_d       = cap_end_r_q;
                end_c_d       = cap_end_c_q;
            end else begin
                palm_width_d  = 8'd0;
                palm_height_d = 8'd0;
                start_r_d     = 8'd0;
                start_c_d     = 8'd0;
                end_r_d       = 8'd0;
                end_c_d       = 8'd0;
            end
        end
    end

    // Run tracking, row close and block open/extend/close decisions.
    always_comb begin
        col_d = col_q;                 row_d = row_q;
        cur_len_d = cur_len_q;         cur_start_d = cur_start_q;
        max_len_d = max_len_q;         max_start_d = max_start_q;   max_end_d = max_end_q;
        blk_open_d = blk_open_q;       blk_start_r_d = blk_start_r_q; blk_end_r_d = blk_end_r_q;
        blk_rows_d = blk_rows_q;       blk_min_c_d = blk_min_c_q;   blk_max_c_d = blk_max_c_q;
        cap_valid_d = cap_valid_q;     cap_start_r_d = cap_start_r_q; cap_end_r_d = cap_end_r_q;
        cap_start_c_d = cap_start_c_q; cap_end_c_d = cap_end_c_q;
        run_len = 8'd0;
        run_start = 8'd0;
        qualifies = 1'b0;
        close_blk = 1'b0;

        // A new frame forgets any block or capture from the previous scan.
        if (restart) begin
            blk_open_d = 1'b0;    blk_start_r_d = 8'd0; blk_end_r_d = 8'd0;
            blk_rows_d = 8'd0;    blk_min_c_d = 8'd0;   blk_max_c_d = 8'd0;
            cap_valid_d = 1'b0;   cap_start_r_d = 8'd0; cap_end_r_d = 8'd0;
            cap_start_c_d = 8'd0; cap_end_c_d = 8'd0;
        end

        if (accept) begin
            if (eff_col == 8'd0) begin
                cur_len_d = 8'd0; cur_start_d = 8'd0;
                max_len_d = 8'd0; max_start_d = 8'd0; max_end_d = 8'd0;
            end
            if (object_image) begin
                if (cur_len_d == 8'd0) begin
                    run_len   = 8'd1;
                    run_start = eff_col;
                end else begin
                    run_len   = (cur_len_d == 8'hFF) ? 8'hFF : cur_len_d + 8'd1;
                    run_start = cur_start_d;
                end
            end
            cur_len_d   = run_len;
            cur_start_d = run_start;
            // The growing run takes over the row record once strictly longer,
            // so its end column follows the run until it stops.
            if (run_len > max_len_d) begin
                max_len_d   = run_len;
                max_start_d = run_start;
                max_end_d   = eff_col;
            end
            if (row_end) begin
                col_d = 8'd0;
                row_d = (eff_row == LAST_ROW) ? 8'd0 : eff_row + 8'd1;
                qualifies = (max_len_d >= MIN_RUN);
                if (qualifies) begin
                    if (!blk_open_d) begin
                        blk_open_d    = 1'b1;
                        blk_start_r_d = eff_row;
                        blk_min_c_d   = max_start_d;
                        blk_max_c_d   = max_end_d;
                        blk_rows_d    = 8'd1;
                    end else begin
                        blk_rows_d  = blk_rows_d + 8'd1;
                        blk_min_c_d = (max_start_d < blk_min_c_d) ? max_start_d : blk_min_c_d;
                        blk_max_c_d = (max_end_d > blk_max_c_d) ? max_end_d : blk_max_c_d;
                    end
                    blk_end_r_d = eff_row;
                end else begin
                    close_blk = blk_open_d;
                end
            end else begin
                col_d = eff_col + 8'd1;
                row_d = eff_row;
            end
        end

        // A block still open after the last row is judged in CLOSE.
        if (state_q == S_CLOSE) close_blk = blk_open_d;

        if (close_blk) begin
            if (blk_rows_d >= MIN_ROWS && !cap_valid_d) begin
                cap_valid_d   = 1'b1;
                cap_start_r_d = blk_start_r_d;
                cap_end_r_d   = blk_end_r_d;
                cap_start_c_d = blk_min_c_d;
                cap_end_c_d   = blk_max_c_d;
            end
            blk_open_d = 1'b0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;         row_q <= '0;
            cur_len_q <= '0;     cur_start_q <= '0;
            max_len_q <= '0;     max_start_q <= '0;   max_end_q <= '0;
            blk_open_q <= 1'b0;  blk_start_r_q <= '0; blk_end_r_q <= '0;
            blk_rows_q <= '0;    blk_min_c_q <= '0;   blk_max_c_q <= '0;
            cap_valid_q <= 1'b0; cap_start_r_q <= '0; cap_end_r_q <= '0;
            cap_start_c_q <= '0; cap_end_c_q <= '0;
            palm_width_q <= '0;  palm_height_q <= '0;
            start_r_q <= '0;     start_c_q <= '0;     end_r_q <= '0;     end_c_q <= '0;
            palm_done_q <= 1'b0;
        end else begin
            col_q <= col_d;                 row_q <= row_d;
            cur_len_q <= cur_len_d;         cur_start_q <= cur_start_d;
            max_len_q <= max_len_d;         max_start_q <= max_start_d;   max_end_q <= max_end_d;
            blk_open_q <= blk_open_d;       blk_start_r_q <= blk_start_r_d; blk_end_r_q <= blk_end_r_d;
            blk_rows_q <= blk_rows_d;       blk_min_c_q <= blk_min_c_d;   blk_max_c_q <= blk_max_c_d;
            cap_valid_q <= cap_valid_d;     cap_start_r_q <= cap_start_r_d; cap_end_r_q <= cap_end_r_d;
            cap_start_c_q <= cap_start_c_d; cap_end_c_q <= cap_end_c_d;
            palm_width_q <= palm_width_d;   palm_height_q <= palm_height_d;
            start_r_q <= start_r_d;         start_c_q <= start_c_d;
            end_r_q <= end_r_d;             end_c_q <= end_c_d;
            palm_done_q <= palm_done_d;
        end
    end

    assign palm_width      = palm_width_q;
    assign palm_height     = palm_height_q;
    assign start_of_palm_r = start_r_q;
    assign start_of_palm_c = start_c_q;
    assign end_of_palm_r   = end_r_q;
    assign end_of_palm_c   = end_c_q;
    assign palm_done       = palm_done_q;

endmodule

// File: doc/palm_locator.md
Name: palm_locator

Overview:
- Upstream producer of the palm-box interface used by finger identification.
- Scans a raster-ordered binary object image, one pixel per accepted clock.
- Finds the first vertical block of rows that contain a wide run of object pixels, and publishes that block's bounding box once per frame.
- Publishes palm_width = 0 when no palm is found, so downstream finger logic stays idle.

Parameters:
- IMAGE_WIDTH, 120, pixels per row (columns 0..IMAGE_WIDTH-1)
- IMAGE_HEIGHT, 160, rows per frame (rows 0..IMAGE_HEIGHT-1)
- MIN_PALM_RUN, 20, minimum contiguous 1-pixel run for a row to qualify as palm
- MIN_PALM_ROWS, 8, minimum consecutive qualifying rows to accept a block as palm

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- frame_start  input  1  pulse coinciding with pixel (0,0); restarts the scan
- pixel_valid  input  1  object_image is valid this cycle
- object_image  input  1  binary pixel, 1 = object
- palm_width  output  8  end_of_palm_c - start_of_palm_c + 1, or 0 if no palm
- palm_height  output  8  end_of_palm_r - start_of_palm_r + 1, or 0 if no palm
- start_of_palm_r  output  8  first row of the palm block
- start_of_palm_c  output  8  leftmost run start column over the block
- end_of_palm_r  output  8  last row of the palm block
- end_of_palm_c  output  8  rightmost run end column over the block
- palm_done  output  1  one-cycle pulse when outputs update
- busy  output  1  high in SCAN and CLOSE

Behaviour:
- Reset (async, active-high): all outputs 0, FSM in IDLE, all counters and trackers 0.
- FSM states:
  - IDLE: wait for frame_start & pixel_valid. That pixel is processed as (0,0), then go to SCAN.
  - SCAN: accept pixels on each pixel_valid. Gaps in pixel_valid stall all counters.
  - CLOSE: one cycle of final block evaluation.
  - PUBLISH: register outputs, pulse palm_done, return to IDLE.
- Counters:
  - col and row are 8-bit.
  - col wraps at IMAGE_WIDTH-1 to 0 and increments row.
  - After row IMAGE_HEIGHT-1 / col IMAGE_WIDTH-1 is accepted, go to CLOSE.
- Run tracking per row:
  - cur_len counts consecutive 1s and saturates at 255. cur_start latches col at a 0→1 transition, or at col 0 when the pixel is 1.
  - A run ends on a 0 pixel or at the row's last pixel; the last pixel is included in the run.
  - Row record is max_len, max_start, max_end. Replace only on a strictly greater length, so ties keep the earliest run.
  - All run state clears at the start of each row.
- Row close, at the last column of a row:
  - The row qualifies iff max_len >= MIN_PALM_RUN.
  - If it qualifies: on the first such row, open a block (blk_start_r = row, min_c = max_start, max_c = max_end, blk_rows = 1). Otherwise extend the block: blk_rows+1, min_c = min(min_c, max_start), max_c = max(max_c, max_end), blk_end_r = row.
  - If it does not qualify and a block is open, close the block. If blk_rows >= MIN_PALM_ROWS and no palm is captured yet, capture the block; otherwise discard it.
- CLOSE state: an open block is evaluated with the same rule, so a block reaching row IMAGE_HEIGHT-1 can still be captured.
- Capture policy: only the first accepted block per frame is captured; later blocks are ignored.
- Latency:
  - Last pixel accepted at edge E.
  - CLOSE runs at edge E+1.
  - Outputs update at edge E+2, with palm_done high for the following cycle.
- Output hold:
  - Outputs hold their values until the next PUBLISH. They do not clear at frame_start.
  - With no palm, PUBLISH drives all six box outputs to 0.
- frame_start in SCAN: abort the current scan, clear all trackers, and treat that pixel as (0,0). No palm_done is issued for the aborted frame.
- Arithmetic: widths are computed in 8 bits. Values are bounded by the image size, so no overflow occurs at the defaults.
- Async reset mid-frame: immediate return to IDLE with all outputs 0.

Test Plan:
- Empty frame (all 0, 160x120): palm_done pulses exactly 2 cycles after the last pixel; all box outputs 0.
- Rectangle of 1s, rows 40..79, cols 30..69: start_r=40, end_r=79, start_c=30, end_c=69, width=40, height=40.
- Block of only 7 rows of 30-pixel runs at rows 10..16, then a valid block at rows 50..89, cols 20..59: captures the second block (start_r=50, height=40).
- Runs touching col 0 and col 119 (row 100..159, cols 0..119): start_c=0, end_c=119, width=120, end_r=159, captured via CLOSE.
- Random pixel_valid gaps (50% duty) on the rectangle case: identical results to the gapless run; palm_done delayed only by the gaps.
- frame_start at row 30 mid-frame, then a full rectangle frame: no palm_done for the aborted frame; second frame correct. Async rst during SCAN: outputs 0 within the same cycle.
